// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART receiver control FSM: frame tracking, check strobes, valid/error pulses
module uart_rx_fsm #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      RX_IN,
  input  logic                      PAR_EN,
  input  logic [PRESCALE_WIDTH-1:0] Prescale,
  input  logic                      strt_glitch,
  input  logic                      par_err,
  input  logic                      stp_err,
  output logic [PRESCALE_WIDTH-1:0] edge_cnt,
  output logic [3:0]                bit_cnt,
  output logic                      dat_samp_en,
  output logic                      strt_chk_en,
  output logic                      par_chk_en,
  output logic                      stp_chk_en,
  output logic                      deser_en,
  output logic                      data_valid,
  output logic                      frame_err,
  output logic                      busy
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  localparam logic [PRESCALE_WIDTH-1:0] P_MIN     = PRESCALE_WIDTH'(4);
  localparam logic [3:0]                LAST_DATA = 4'(DATA_WIDTH);

  state_t                    state;
  logic [PRESCALE_WIDTH-1:0] p_lat;
  logic                      par_en_lat;
  logic                      par_flag;
  logic [PRESCALE_WIDTH-1:0] prescale_eff;
  logic                      check_edge;
  logic                      end_edge;

  // Ratios below 4 leave no room for separate check and end edges, so clamp them.
  assign prescale_eff = (Prescale < P_MIN) ? P_MIN : Prescale;
  assign check_edge   = (edge_cnt == p_lat - PRESCALE_WIDTH'(2));
  assign end_edge     = (edge_cnt == p_lat - PRESCALE_WIDTH'(1));

  // Frame sequencing: state, edge/bit counters, latched frame settings and sticky parity error.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      edge_cnt   <= '0;
      bit_cnt    <= '0;
      p_lat      <= P_MIN;
      par_en_lat <= 1'b0;
      par_flag   <= 1'b0;
    end else if (state == IDLE) begin
      edge_cnt <= '0;
      bit_cnt  <= '0;
      par_flag <= 1'b0;
      if (!RX_IN) begin
        state      <= START;
        p_lat      <= prescale_eff;
        par_en_lat <= PAR_EN;
      end
    end else begin
      if (end_edge) begin
        edge_cnt <= '0;
        bit_cnt  <= bit_cnt + 4'd1;
      end else begin
        edge_cnt <= edge_cnt + PRESCALE_WIDTH'(1);
      end
      case (state)
        START: begin
          if (end_edge) begin
            if (strt_glitch) begin
              state    <= IDLE;
              bit_cnt  <= '0;
              par_flag <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (end_edge && bit_cnt == LAST_DATA) begin
            state <= par_en_lat ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (end_edge) begin
            par_flag <= par_err;
            state    <= STOP;
          end
        end
        STOP: begin
          if (end_edge) begin
            state    <= IDLE;
            bit_cnt  <= '0;
            par_flag <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          edge_cnt <= '0;
          bit_cnt  <= '0;
        end
      endcase
    end
  end

  // Strobes and result pulses decoded from registered state; stp_err is already registered upstream.
  always_comb begin
    busy        = (state != IDLE);
    dat_samp_en = busy;
    strt_chk_en = (state == START)  && check_edge;
    deser_en    = (state == DATA)   && check_edge;
    par_chk_en  = (state == PARITY) && check_edge;
    stp_chk_en  = (state == STOP)   && check_edge;
    data_valid  = (state == STOP) && end_edge && !stp_err && !par_flag;
    frame_err   = (state == STOP) && end_edge && (stp_err || par_flag);
  end

endmodule

// File: tb/tb_uart_rx_fsm.sv
// tb/tb_uart_rx_fsm.sv - directed bench for uart_rx_fsm with behavioural line and checker models
module tb_uart_rx_fsm;

  logic       CLK = 1'b0;
  logic       RST;
  logic       RX_IN;
  logic       PAR_EN;
  logic [5:0] Prescale;
  logic       strt_glitch;
  logic       par_err;
  logic       stp_err;
  logic [5:0] edge_cnt;
  logic [3:0] bit_cnt;
  logic       dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en;
  logic       data_valid, frame_err, busy;

  uart_rx_fsm #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
    .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
    .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
    .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en),
    .deser_en(deser_en), .data_valid(data_valid), .frame_err(frame_err), .busy(busy)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int passed = 0;

  logic [15:0] bits = 16'hFFFF;
  logic [7:0]  cur_data = 8'h00;
  bit          start_req = 1'b0;
  bit          glitch_mode = 1'b0;

  // Serial line: follows the frame bit the DUT is in; in idle, low only when a start is requested.
  always_comb begin
    if (busy) begin
      if (glitch_mode && bit_cnt == 4'd0) RX_IN = (edge_cnt == 6'd0) ? 1'b0 : 1'b1;
      else                                RX_IN = bits[bit_cnt];
    end else begin
      RX_IN = ~start_req;
    end
  end

  // Registered start/parity(even)/stop checker models.
  always @(posedge CLK) begin
    if (RST) begin
      strt_glitch <= 1'b0;
      par_err     <= 1'b0;
      stp_err     <= 1'b0;
    end else begin
      if (strt_chk_en) strt_glitch <= RX_IN;
      if (par_chk_en)  par_err     <= RX_IN ^ (^cur_data);
      if (stp_chk_en)  stp_err     <= ~RX_IN;
    end
  end

  int         n_deser = 0, n_valid = 0, n_ferr = 0, n_par = 0, n_viol = 0;
  logic [7:0] shreg = 8'h00;
  logic [7:0] last_byte = 8'h00;
  int         stp_bit = -1, stp_edge = -1, par_bit = -1, par_edge = -1;

  // Monitor: counts strobes/pulses, deserializes LSB first, flags protocol violations.
  always @(negedge CLK) begin
    if (deser_en) begin
      n_deser++;
      shreg = {RX_IN, shreg[7:1]};
    end
    if (data_valid) begin
      n_valid++;
      last_byte = shreg;
    end
    if (frame_err) n_ferr++;
    if (stp_chk_en) begin
      stp_bit  = int'(bit_cnt);
      stp_edge = int'(edge_cnt);
    end
    if (par_chk_en) begin
      n_par++;
      par_bit  = int'(bit_cnt);
      par_edge = int'(edge_cnt);
    end
    if ((data_valid && frame_err) || (dat_samp_en !== busy) ||
        (!busy && (strt_chk_en || par_chk_en || stp_chk_en || deser_en || data_valid || frame_err)))
      n_viol++;
  end

  function automatic logic [15:0] make_bits(input logic [7:0] d, input bit par, input bit par_bad,
                                            input bit stop);
    logic [15:0] b;
    b      = 16'hFFFF;
    b[0]   = 1'b0;
    b[8:1] = d;
    if (par) begin
      b[9]  = (^d) ^ par_bad;
      b[10] = stop;
    end else begin
      b[9] = stop;
    end
    return b;
  endfunction

  task automatic tick();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_busy(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (busy) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (data_valid || frame_err) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic start_frame(input logic [7:0] d, input bit par, input bit par_bad, input bit stop,
                             input logic [5:0] presc, output bit ok);
    cur_data  = d;
    PAR_EN    = par;
    Prescale  = presc;
    bits      = make_bits(d, par, par_bad, stop);
    start_req = 1'b1;
    wait_busy(20, ok);
    start_req = 1'b0;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid, frame_err} !== 8'h00)
      $display("FAIL reset_outputs: got %b required 00000000",
               {busy, dat_samp_en, strt_chk_en, par_chk_en, stp_chk_en, deser_en, data_valid, frame_err});
    else passed++;
    checks++;
    if ({edge_cnt, bit_cnt} !== 10'd0) $display("FAIL reset_counters: got edge %0d bit %0d required 0 0", edge_cnt, bit_cnt);
    else passed++;
    RST = 1'b0;
    tick();
  endtask

  task automatic test_frame_no_parity();
    bit ok;
    int d0, v0;
    d0 = n_deser;
    v0 = n_valid;
    start_frame(8'hA5, 1'b0, 1'b0, 1'b1, 6'd8, ok);
    checks++;
    if (!ok) $display("FAIL np_start: busy never rose"); else passed++;
    wait_done(200, ok);
    checks++;
    if (!ok) $display("FAIL np_done: no data_valid/frame_err within budget"); else passed++;
    checks++;
    if ({data_valid, frame_err} !== 2'b10) $display("FAIL np_pulse: got valid %b err %b required 1 0", data_valid, frame_err);
    else passed++;
    checks++;
    if (bit_cnt !== 4'd9 || edge_cnt !== 6'd7) $display("FAIL np_valid_pos: got bit %0d edge %0d required 9 7", bit_cnt, edge_cnt);
    else passed++;
    checks++;
    if (stp_bit !== 9 || stp_edge !== 6) $display("FAIL np_stp_chk_pos: got bit %0d edge %0d required 9 6", stp_bit, stp_edge);
    else passed++;
    checks++;
    if (n_deser - d0 !== 8) $display("FAIL np_deser_count: got %0d required 8", n_deser - d0);
    else passed++;
    checks++;
    if (last_byte !== 8'hA5) $display("FAIL np_data: got %h required a5", last_byte);
    else passed++;
    tick();
    checks++;
    if (busy !== 1'b0 || data_valid !== 1'b0 || n_valid - v0 !== 1)
      $display("FAIL np_after: got busy %b valid %b pulses %0d required 0 0 1", busy, data_valid, n_valid - v0);
    else passed++;
  endtask

  task automatic test_frame_parity();
    bit ok;
    int p0, d0;
    p0 = n_par;
    d0 = n_deser;
    start_frame(8'h3C, 1'b1, 1'b0, 1'b1, 6'd16, ok);
    wait_done(400, ok);
    checks++;
    if (!ok || data_valid !== 1'b1) $display("FAIL par_valid: got done %b valid %b required 1 1", ok, data_valid);
    else passed++;
    checks++;
    if (bit_cnt !== 4'd10 || edge_cnt !== 6'd15) $display("FAIL par_valid_pos: got bit %0d edge %0d required 10 15", bit_cnt, edge_cnt);
    else passed++;
    checks++;
    if (n_par - p0 !== 1 || par_bit !== 9 || par_edge !== 14)
      $display("FAIL par_chk: got count %0d bit %0d edge %0d required 1 9 14", n_par - p0, par_bit, par_edge);
    else passed++;
    checks++;
    if (last_byte !== 8'h3C || n_deser - d0 !== 8) $display("FAIL par_data: got %h/%0d required 3c/8", last_byte, n_deser - d0);
    else passed++;
    tick();
    // Same byte with the parity bit flipped must end as a frame error.
    start_frame(8'h3C, 1'b1, 1'b1, 1'b1, 6'd16, ok);
    wait_done(400, ok);
    checks++;
    if (!ok || {data_valid, frame_err} !== 2'b01 || bit_cnt !== 4'd10)
      $display("FAIL par_bad: got done %b valid %b err %b bit %0d required 1 0 1 10", ok, data_valid, frame_err, bit_cnt);
    else passed++;
    tick();
  endtask

  task automatic test_stop_error();
    bit ok;
    int v0;
    v0 = n_valid;
    start_frame(8'h5A, 1'b0, 1'b0, 1'b0, 6'd8, ok);
    wait_done(200, ok);
    checks++;
    if (!ok || {data_valid, frame_err} !== 2'b01)
      $display("FAIL stop_err_pulse: got done %b valid %b err %b required 1 0 1", ok, data_valid, frame_err);
    else passed++;
    tick();
    checks++;
    if (busy !== 1'b0 || n_valid - v0 !== 0) $display("FAIL stop_err_after: got busy %b valid pulses %0d required 0 0", busy, n_valid - v0);
    else passed++;
  endtask

  task automatic test_start_glitch();
    bit ok;
    int d0, v0, f0, cyc;
    d0 = n_deser;
    v0 = n_valid;
    f0 = n_ferr;
    glitch_mode = 1'b1;
    start_frame(8'h00, 1'b0, 1'b0, 1'b1, 6'd8, ok);
    cyc = 0;
    while (busy && cyc < 50) begin
      cyc++;
      tick();
    end
    checks++;
    if (cyc !== 8) $display("FAIL glitch_busy_cycles: got %0d required 8", cyc);
    else passed++;
    checks++;
    if (n_deser - d0 !== 0 || n_valid - v0 !== 0 || n_ferr - f0 !== 0)
      $display("FAIL glitch_no_output: got deser %0d valid %0d err %0d required 0 0 0", n_deser - d0, n_valid - v0, n_ferr - f0);
    else passed++;
    glitch_mode = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    int v0, f0, n;
    v0 = n_valid;
    f0 = n_ferr;
    start_frame(8'hFF, 1'b0, 1'b0, 1'b1, 6'd32, ok);
    n = 0;
    while (bit_cnt != 4'd4 && n < 400) begin
      n++;
      tick();
    end
    checks++;
    if (bit_cnt !== 4'd4) $display("FAIL rst_reach_bit4: got bit %0d required 4", bit_cnt);
    else passed++;
    RST = 1'b1;
    tick();
    RST = 1'b0;
    checks++;
    if (busy !== 1'b0 || edge_cnt !== 6'd0 || bit_cnt !== 4'd0)
      $display("FAIL rst_mid_state: got busy %b edge %0d bit %0d required 0 0 0", busy, edge_cnt, bit_cnt);
    else passed++;
    repeat (400) tick();
    checks++;
    if (n_valid - v0 !== 0 || n_ferr - f0 !== 0)
      $display("FAIL rst_mid_no_pulse: got valid %0d err %0d required 0 0", n_valid - v0, n_ferr - f0);
    else passed++;
    start_frame(8'h81, 1'b0, 1'b0, 1'b1, 6'd8, ok);
    wait_done(200, ok);
    checks++;
    if (!ok || data_valid !== 1'b1 || last_byte !== 8'h81)
      $display("FAIL rst_next_frame: got done %b valid %b data %h required 1 1 81", ok, data_valid, last_byte);
    else passed++;
    tick();
  endtask

  task automatic test_back_to_back();
    bit ok;
    int v0, n;
    v0 = n_valid;
    cur_data  = 8'h55;
    PAR_EN    = 1'b0;
    Prescale  = 6'd8;
    bits      = make_bits(8'h55, 1'b0, 1'b0, 1'b1);
    start_req = 1'b1;
    wait_busy(20, ok);
    n = 0;
    while (bit_cnt != 4'd4 && n < 200) begin
      n++;
      tick();
    end
    Prescale = 6'd16;
    wait_done(200, ok);
    checks++;
    if (!ok || data_valid !== 1'b1 || bit_cnt !== 4'd9 || edge_cnt !== 6'd7 || last_byte !== 8'h55)
      $display("FAIL b2b_frame1: got valid %b bit %0d edge %0d data %h required 1 9 7 55", data_valid, bit_cnt, edge_cnt, last_byte);
    else passed++;
    cur_data = 8'hAA;
    bits     = make_bits(8'hAA, 1'b0, 1'b0, 1'b1);
    tick();
    checks++;
    if (busy !== 1'b0) $display("FAIL b2b_slip: got busy %b required 0", busy);
    else passed++;
    tick();
    checks++;
    if (busy !== 1'b1 || edge_cnt !== 6'd0) $display("FAIL b2b_restart: got busy %b edge %0d required 1 0", busy, edge_cnt);
    else passed++;
    start_req = 1'b0;
    wait_done(400, ok);
    checks++;
    if (!ok || data_valid !== 1'b1 || bit_cnt !== 4'd9 || edge_cnt !== 6'd15 || last_byte !== 8'hAA)
      $display("FAIL b2b_frame2: got valid %b bit %0d edge %0d data %h required 1 9 15 aa", data_valid, bit_cnt, edge_cnt, last_byte);
    else passed++;
    tick();
    checks++;
    if (n_valid - v0 !== 2) $display("FAIL b2b_count: got %0d required 2", n_valid - v0);
    else passed++;
  endtask

  initial begin
    RST      = 1'b1;
    PAR_EN   = 1'b0;
    Prescale = 6'd8;
    test_reset();
    test_frame_no_parity();
    test_frame_parity();
    test_stop_error();
    test_start_glitch();
    test_reset_mid_frame();
    test_back_to_back();
    checks++;
    if (n_viol !== 0) $display("FAIL protocol_violations: got %0d required 0", n_viol);
    else passed++;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
